// File: rtl/issue_hazard_unit.sv
// Decode-stage issue gate sitting between IF/ID and the control unit.
// Each cycle it either forwards the fetched instruction or substitutes a stall
// instruction. Substitution happens for RAW hazards against recently issued
// destinations, for the follow-up cycles of vector loads and stores, and for
// branch flushes. While a substitution is in progress it holds the fetch stage.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   in_valid                 IF/ID holds a real instruction
//   instruction_type_i       fetched instruction class
//   opcode_i                 fetched opcode
//   rd_i                     destination register address
//   src{1,2}_used_i          source operand is read
//   src{1,2}_vec_i           source is a vector register (else scalar)
//   src{1,2}_i               source register addresses
//   flush_i                  taken branch in EX; kill the decode-stage instruction
//   stall_fetch              hold PC and IF/ID this cycle (combinational)
//   instruction_type_o       registered class to the control unit
//   opcode_o                 registered opcode to the control unit
//   rd_o, src1_o, src2_o     registered register fields
//   bubble_o                 registered; current output is a substituted stall
module issue_hazard_unit #(
    parameter int unsigned REG_W         = 4,
    parameter int unsigned HAZARD_WINDOW = 3,
    parameter int unsigned VMEM_CYCLES   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       instruction_type_i,
    input  logic [4:0]       opcode_i,
    input  logic [REG_W-1:0] rd_i,
    input  logic             src1_used_i,
    input  logic             src2_used_i,
    input  logic             src1_vec_i,
    input  logic             src2_vec_i,
    input  logic [REG_W-1:0] src1_i,
    input  logic [REG_W-1:0] src2_i,
    input  logic             flush_i,
    output logic             stall_fetch,
    output logic [1:0]       instruction_type_o,
    output logic [4:0]       opcode_o,
    output logic [REG_W-1:0] rd_o,
    output logic [REG_W-1:0] src1_o,
    output logic [REG_W-1:0] src2_o,
    output logic             bubble_o
);

    localparam int unsigned CNT_W       = 4;
    localparam logic [1:0]  TYPE_STALL  = 2'b01;
    localparam logic [4:0]  OP_STALL    = 5'b00101;
    localparam logic [4:0]  OP_STALL_RD = 5'b00110;
    localparam logic [4:0]  OP_STALL_WR = 5'b00111;

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_VLD   = 2'd1,
        ST_VST   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;

    // Scoreboard of recently issued destinations, entry 0 is the youngest
    logic [HAZARD_WINDOW-1:0]            sb_valid;
    logic [HAZARD_WINDOW-1:0]            sb_vec;
    logic [HAZARD_WINDOW-1:0][REG_W-1:0] sb_addr;

    logic is_scalar_wr;
    logic is_vec_wr;
    logic is_vld;
    logic is_vst;
    logic raw;
    logic hazard;

    logic [1:0]       type_d;
    logic [4:0]       op_d;
    logic [REG_W-1:0] rd_d;
    logic [REG_W-1:0] src1_d;
    logic [REG_W-1:0] src2_d;
    logic             bubble_d;
    logic             sb_ld_valid;
    logic             sb_ld_vec;

    // Destination class of the fetched instruction
    always_comb begin
        is_scalar_wr = ((instruction_type_i == 2'b01) && ((opcode_i <= 5'd4) || opcode_i[4]))
                    || ((instruction_type_i == 2'b00) && (opcode_i[4:3] == 2'b00));
        is_vec_wr    = (instruction_type_i == 2'b11)
                    || ((instruction_type_i == 2'b00) && (opcode_i[4:3] == 2'b10));
        is_vld       = (instruction_type_i == 2'b00) && (opcode_i[4:3] == 2'b10);
        is_vst       = (instruction_type_i == 2'b00) && (opcode_i[4:3] == 2'b11);
    end

    // RAW check; scalar and vector register files are separate namespaces
    always_comb begin
        raw = 1'b0;
        for (int i = 0; i < int'(HAZARD_WINDOW); i++) begin
            if (sb_valid[i]) begin
                if (src1_used_i && (src1_vec_i == sb_vec[i]) && (src1_i == sb_addr[i])) begin
                    raw = 1'b1;
                end
                if (src2_used_i && (src2_vec_i == sb_vec[i]) && (src2_i == sb_addr[i])) begin
                    raw = 1'b1;
                end
            end
        end
        hazard = in_valid && raw;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_ISSUE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        case (state)
            ST_ISSUE: begin
                if (!flush_i && !hazard && in_valid) begin
                    if (is_vld) begin
                        state_nxt = ST_VLD;
                        count_nxt = CNT_W'(VMEM_CYCLES);
                    end else if (is_vst) begin
                        state_nxt = ST_VST;
                        count_nxt = CNT_W'(VMEM_CYCLES);
                    end
                end
            end
            ST_VLD, ST_VST: begin
                if (flush_i) begin
                    state_nxt = ST_ISSUE;
                    count_nxt = '0;
                end else begin
                    count_nxt = count - CNT_W'(1);
                    // Last follow-up cycle: the count reaches zero on this edge
                    if (count == CNT_W'(1)) begin
                        state_nxt = ST_ISSUE;
                    end
                end
            end
            default: begin
                state_nxt = ST_ISSUE;
                count_nxt = '0;
            end
        endcase
    end

    // Output logic: next values of the output registers, scoreboard load, fetch hold
    always_comb begin
        type_d      = TYPE_STALL;
        op_d        = OP_STALL;
        rd_d        = '0;
        src1_d      = '0;
        src2_d      = '0;
        bubble_d    = 1'b1;
        sb_ld_valid = 1'b0;
        sb_ld_vec   = 1'b0;
        stall_fetch = 1'b0;
        case (state)
            ST_ISSUE: begin
                if (flush_i) begin
                    stall_fetch = 1'b0;
                end else if (hazard) begin
                    stall_fetch = 1'b1;
                end else if (in_valid) begin
                    type_d      = instruction_type_i;
                    op_d        = opcode_i;
                    rd_d        = rd_i;
                    src1_d      = src1_i;
                    src2_d      = src2_i;
                    bubble_d    = 1'b0;
                    sb_ld_valid = is_scalar_wr || is_vec_wr;
                    sb_ld_vec   = is_vec_wr;
                end
            end
            ST_VLD, ST_VST: begin
                if (!flush_i) begin
                    // Keep the memory op's register fields on the bus during follow-ups
                    op_d        = (state == ST_VLD) ? OP_STALL_RD : OP_STALL_WR;
                    rd_d        = rd_o;
                    src1_d      = src1_o;
                    src2_d      = src2_o;
                    stall_fetch = 1'b1;
                end
            end
            default: begin
                stall_fetch = 1'b0;
            end
        endcase
    end

    // Output registers and scoreboard shift
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instruction_type_o <= TYPE_STALL;
            opcode_o           <= OP_STALL;
            rd_o               <= '0;
            src1_o             <= '0;
            src2_o             <= '0;
            bubble_o           <= 1'b1;
            sb_valid           <= '0;
            sb_vec             <= '0;
            sb_addr            <= '0;
        end else begin
            instruction_type_o <= type_d;
            opcode_o           <= op_d;
            rd_o               <= rd_d;
            src1_o             <= src1_d;
            src2_o             <= src2_d;
            bubble_o           <= bubble_d;
            for (int i = 1; i < int'(HAZARD_WINDOW); i++) begin
                sb_valid[i] <= sb_valid[i-1];
                sb_vec[i]   <= sb_vec[i-1];
                sb_addr[i]  <= sb_addr[i-1];
            end
            sb_valid[0] <= sb_ld_valid;
            sb_vec[0]   <= sb_ld_vec;
            sb_addr[0]  <= rd_d;
        end
    end

endmodule
